jk_cmd_seq: RTL and testbench
=============================

# jk_cmd_seq

Command sequencer that sits directly upstream of the JK flip-flop stage and drives its `jk[1:0]` input. It accepts JK operations with a repeat count over a valid/ready handshake and buffers them in a small FIFO. It replays each operation on `jk` for the requested number of cycles. It also tracks the flip-flop's expected state and flags any mismatch on the fed-back `q`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, minimum 2.
- `CNT_W`, 4: width of the repeat-count field.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting it (0) clears all state immediately. Release is synchronous to `clk`.
- `in_valid` input 1: upstream command valid.
- `in_ready` output 1: FIFO can accept a command; `in_ready = !full`.
- `in_op` input 2: operation. 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- `in_cnt` input CNT_W: repeat count; the command is driven for `in_cnt+1` cycles.
- `jk` output 2: drive to the JK flip-flop's `jk` input; registered.
- `q_fb` input 1: the JK flip-flop's `q`, fed back.
- `busy` output 1: a command is executing or the FIFO is non-empty.
- `done` output 1: one-cycle pulse; the last cycle of a command has completed.
- `err` output 1: sticky mismatch between `q_fb` and the predicted state.

## Operation
- **Push:** a command is written on a rising edge when `in_valid && in_ready`. When the FIFO is full, `in_ready` is 0 and the command is not taken, even if a pop happens in the same cycle.
- **FSM states:**
  - IDLE: `jk` = 00.
  - RUN: `jk` = current op; a `remain` counter (CNT_W bits) tracks cycles left.
- **IDLE → RUN:** on an edge with the FIFO non-empty. The head is popped, the op is loaded into the `jk` register, and `remain` = cnt.
- **Within RUN:** each edge with `remain != 0` decrements `remain`; `jk` is unchanged.
- **End of command:** on an edge with `remain == 0`, `done` is set for one cycle. Then:
  - FIFO non-empty: pop the next command with no bubble and stay in RUN.
  - FIFO empty: go to IDLE with `jk` = 00.
- `in_cnt` = 0 gives a single cycle; `in_cnt` = 2^CNT_W−1 gives 2^CNT_W cycles. There is no wrap of `remain`.
- **Shadow model:** updated on every edge from the `jk` value currently driven.
  - RESET → shadow 0, SET → shadow 1; either one sets `shv`=1.
  - TOGGLE → `~shadow`. HOLD → unchanged.
  - `shv` stays 0 until the first SET or RESET has been issued, because the flip-flop's initial `q` is unknown.
- **Check:** each cycle with `shv`=1, if `q_fb != shadow` then `err` is set on the next edge. `err` is cleared only by `rst`.
- **Flip-flop's own reset:** the downstream flip-flop's synchronous reset must be held deasserted while this block runs. Any flip-flop reset while `shv`=1 is reported as `err` unless the shadow was 0.
- `busy` = (state == RUN) || !empty; combinational from registers.

## Timing
- **Reset values:** `jk`=00, `in_ready`=1, `busy`=0, `done`=0, `err`=0. Also: state=IDLE, FIFO empty, `shv`=0, shadow=0.
- **Latency:** a command pushed at edge k into an empty FIFO, with the FSM idle, is popped at edge k+1. `jk` shows the op from k+1 and the flip-flop samples it at edges k+2 through k+2+cnt.
- **`done`:** high in the cycle after the last `jk` cycle of the command.
- **Back-to-back commands:** consecutive `jk` values with zero idle cycles between them.
- **Check alignment:** the `q_fb` comparison uses the flip-flop's `q` after the edge that consumed `jk`. The shadow and `q` therefore update on the same edge.
- **Reset mid-command:** asynchronous assertion immediately forces `jk`=00 and discards FIFO contents and the current command. No `done` pulse is generated.
- **Simultaneous push and pop on a non-full FIFO:** both take effect; occupancy is unchanged.

## Test plan
- **Reset then single SET:** push SET cnt=0 at edge 1 → `jk`=10 for one cycle from edge 2, `done`=1 in the cycle after edge 3, `busy` drops after edge 3, `err`=0.
- **Back-to-back commands:** push RESET cnt=1, TOGGLE cnt=2, HOLD cnt=0 → `jk` sequence 01,01,11,11,11,00 with no gaps and three `done` pulses. With the flip-flop connected, `q` goes 0,0,1,0,1,1 and `err` stays 0.
- **Full FIFO:** with the FSM stalled on a long command (HOLD cnt=15), push DEPTH commands → `in_ready`=0. An extra `in_valid` is ignored. `in_ready` returns to 1 one edge after the next pop.
- **Mismatch detection:** after SET, force `q_fb`=0 for one cycle → `err`=1 on the next edge and remains 1 after `q_fb` recovers, until `rst`=0.
- **Async reset mid-RUN:** during TOGGLE cnt=7, drive `rst` low between edges → `jk`=00, `busy`=0, `done`=0 immediately. After release, the FIFO is empty and a new command executes normally.
- **No check before a SET/RESET:** push TOGGLE cnt=3 first with arbitrary `q_fb` → `err` stays 0 because `shv`=0.

Source files
------------

// File: rtl/jk_cmd_seq.sv
// Command sequencer feeding a JK flip-flop stage.
// Commands {op, cnt} are buffered in a small FIFO and each op is replayed on
// jk for cnt+1 cycles. A shadow copy of the flip-flop's expected state is
// compared against the fed-back q, and any divergence latches err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no command executing, jk driven to HOLD (00)
// ST_RUN  | replaying the current op; remain = cycles left after this one
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [CNT_W-1:0] in_cnt,
   output logic [1:0]       jk,
   input  logic             q_fb,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_RESET  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   logic [1:0]       fifo_op  [DEPTH];
   logic [CNT_W-1:0] fifo_cnt [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;

   logic [0:0]       state;
   logic [CNT_W-1:0] remain;
   logic             cmd_end;

   logic             shadow;
   logic             shv;

   // FIFO occupancy flags from the wrap-bit pointer pair
   always_comb begin
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   end

   // Handshake and sequencing strobes; a full FIFO refuses pushes even when
   // a pop happens in the same cycle
   always_comb begin
      in_ready = !full;
      push     = in_valid && !full;
      cmd_end  = (state == ST_RUN) && (remain == '0);
      pop      = !empty && ((state == ST_IDLE) || cmd_end);
      busy     = (state == ST_RUN) || !empty;
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr[AW-1:0]]  <= in_op;
         fifo_cnt[wr_ptr[AW-1:0]] <= in_cnt;
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sequencer FSM: load head with no bubble, count down, return to HOLD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         remain <= '0;
         jk     <= OP_HOLD;
         done   <= 1'b0;
      end else begin
         done <= cmd_end;
         if (pop) begin
            state  <= ST_RUN;
            jk     <= fifo_op[rd_ptr[AW-1:0]];
            remain <= fifo_cnt[rd_ptr[AW-1:0]];
         end else if (cmd_end) begin
            state <= ST_IDLE;
            jk    <= OP_HOLD;
         end else if (state == ST_RUN) begin
            remain <= remain - 1'b1;
         end
      end
   end

   // Shadow of the flip-flop: follows the jk value it is sampling this edge;
   // stays unqualified until a SET or RESET pins down the unknown start value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow <= 1'b0;
         shv    <= 1'b0;
      end else begin
         case (jk)
            OP_RESET: begin
               shadow <= 1'b0;
               shv    <= 1'b1;
            end
            OP_SET: begin
               shadow <= 1'b1;
               shv    <= 1'b1;
            end
            OP_TOGGLE: shadow <= ~shadow;
            default:   shadow <= shadow;
         endcase
      end
   end

   // Sticky mismatch flag; only the block reset clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (shv && (q_fb != shadow)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: a directed vector table, hand-written corner
// sequences, and a random run against a per-cycle jk schedule model.
module tb_jk_cmd_seq;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [CNT_W-1:0] in_cnt;
   logic [1:0]       jk;
   logic             q_fb;
   logic             busy;
   logic             done;
   logic             err;

   logic             ff_q;
   logic             q_flip;

   int n_checks;
   int n_err;

   jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_cnt   (in_cnt),
      .jk       (jk),
      .q_fb     (q_fb),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream JK flip-flop stand-in; its start value is arbitrary (1)
   always @(posedge clk or negedge rst) begin
      if (!rst) ff_q <= 1'b1;
      else begin
         case (jk)
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign q_fb = ff_q ^ q_flip;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_cnt   = '0;
      q_flip   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic push_cmd(input logic [1:0] op, input int cnt);
      in_valid = 1'b1;
      in_op    = op;
      in_cnt   = CNT_W'(cnt);
      tick();
      in_valid = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // Every accepted command expands into cnt+1 per-cycle jk slots; one slot
   // is consumed per edge. A command still counts as queued until its first
   // slot is consumed.
   typedef struct {
      logic [1:0] op;
      bit         first;
      bit         last;
   } slot_t;

   slot_t      sched[$];
   bit         m_cur_valid;
   bit         m_cur_last;
   logic [1:0] m_jk;
   bit         m_done;
   bit         m_shadow;
   bit         m_shv;
   bit         m_err;

   function automatic int queued();
      int n = 0;
      foreach (sched[i]) if (sched[i].first) n++;
      return n;
   endfunction

   task automatic model_reset();
      sched.delete();
      m_cur_valid = 0;
      m_cur_last  = 0;
      m_jk        = 2'b00;
      m_done      = 0;
      m_shadow    = 0;
      m_shv       = 0;
      m_err       = 0;
   endtask

   task automatic model_edge(input bit v, input logic [1:0] op, input int cnt, input bit qf);
      bit    acc;
      slot_t s;
      acc = v && (queued() < DEPTH);
      if (m_shv && (qf != m_shadow)) m_err = 1;
      if (m_jk == 2'b01) begin m_shadow = 0; m_shv = 1; end
      else if (m_jk == 2'b10) begin m_shadow = 1; m_shv = 1; end
      else if (m_jk == 2'b11) m_shadow = !m_shadow;
      m_done = m_cur_valid && m_cur_last;
      if (sched.size() > 0) begin
         s = sched.pop_front();
         m_jk        = s.op;
         m_cur_valid = 1;
         m_cur_last  = s.last;
      end else begin
         m_jk        = 2'b00;
         m_cur_valid = 0;
         m_cur_last  = 0;
      end
      if (acc) begin
         for (int i = 0; i <= cnt; i++) begin
            s.op    = op;
            s.first = (i == 0);
            s.last  = (i == cnt);
            sched.push_back(s);
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       valid;
      logic [1:0] op;
      logic [3:0] cnt;
      logic [1:0] x_jk;
      logic       x_done;
      logic       x_busy;
      logic       x_ready;
      logic       x_err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int  dcnt;
      bit  v;
      logic [1:0] o;
      int  c;
      bit  qf;

      n_checks = 0;
      n_err    = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_cnt   = '0;
      q_flip   = 1'b0;

      // RESET x2, TOGGLE x3, HOLD x1 back to back
      tbl[0] = '{1'b1, 2'b01, 4'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 2'b11, 4'd2, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 2'b00, 4'd0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};

      // reset values
      apply_reset();
      chk("rst_jk",    int'(jk),       0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_busy",  int'(busy),     0);
      chk("rst_done",  int'(done),     0);
      chk("rst_err",   int'(err),      0);

      // back-to-back table
      for (int i = 0; i < 9; i++) begin
         in_valid = tbl[i].valid;
         in_op    = tbl[i].op;
         in_cnt   = tbl[i].cnt;
         tick();
         chk($sformatf("tbl%0d_jk", i),    int'(jk),       int'(tbl[i].x_jk));
         chk($sformatf("tbl%0d_done", i),  int'(done),     int'(tbl[i].x_done));
         chk($sformatf("tbl%0d_busy", i),  int'(busy),     int'(tbl[i].x_busy));
         chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].x_ready));
         chk($sformatf("tbl%0d_err", i),   int'(err),      int'(tbl[i].x_err));
      end

      // single SET cnt=0
      apply_reset();
      push_cmd(2'b10, 0);
      chk("set_e1_jk",   int'(jk),   0);
      chk("set_e1_busy", int'(busy), 1);
      tick();
      chk("set_e2_jk",   int'(jk),   2);
      chk("set_e2_done", int'(done), 0);
      tick();
      chk("set_e3_done", int'(done), 1);
      chk("set_e3_jk",   int'(jk),   0);
      chk("set_e3_busy", int'(busy), 0);
      chk("set_e3_err",  int'(err),  0);
      tick();
      chk("set_e4_done", int'(done), 0);

      // full FIFO behind a 16-cycle HOLD
      apply_reset();
      push_cmd(2'b00, 15);                         // edge 1
      for (int i = 0; i < DEPTH; i++) push_cmd(2'b10, 0);  // edges 2..5
      chk("full_ready", int'(in_ready), 0);
      push_cmd(2'b11, 0);                          // edge 6, refused
      chk("full_ready_hold", int'(in_ready), 0);
      for (int i = 7; i <= 17; i++) tick();
      chk("full_ready_e17", int'(in_ready), 0);
      chk("full_jk_e17",    int'(jk),       0);
      tick();                                      // edge 18: pop
      chk("full_ready_e18", int'(in_ready), 1);
      chk("full_done_e18",  int'(done),     1);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dcnt++;
      end
      chk("full_done_count", dcnt, DEPTH);
      chk("full_end_busy",   int'(busy), 0);
      chk("full_end_q",      int'(ff_q), 1);

      // mismatch detection and stickiness
      apply_reset();
      push_cmd(2'b10, 0);
      tick();
      tick();
      chk("mm_err_pre", int'(err), 0);
      q_flip = 1'b1;
      tick();
      q_flip = 1'b0;
      chk("mm_err_set", int'(err), 1);
      tick();
      tick();
      chk("mm_err_sticky", int'(err), 1);
      rst = 1'b0;
      #1;
      chk("mm_err_clear", int'(err), 0);
      @(negedge clk);
      rst = 1'b1;

      // asynchronous reset during a long TOGGLE
      apply_reset();
      push_cmd(2'b11, 7);
      tick();
      tick();
      tick();
      chk("ar_run_jk",   int'(jk),   3);
      chk("ar_run_busy", int'(busy), 1);
      #1 rst = 1'b0;
      #1;
      chk("ar_jk",   int'(jk),   0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("ar_after_busy",  int'(busy),     0);
      chk("ar_after_ready", int'(in_ready), 1);
      chk("ar_after_jk",    int'(jk),       0);
      push_cmd(2'b01, 0);
      tick();
      chk("ar_new_jk", int'(jk), 1);
      tick();
      chk("ar_new_done", int'(done), 1);

      // no check while the flip-flop state is still unknown
      apply_reset();
      in_valid = 1'b1;
      in_op    = 2'b11;
      in_cnt   = 4'd3;
      q_flip   = 1'($urandom_range(0, 1));
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         q_flip = 1'($urandom_range(0, 1));
         tick();
         chk($sformatf("nochk%0d_err", i), int'(err), 0);
      end
      q_flip = 1'b0;

      // random run against the schedule model
      apply_reset();
      model_reset();
      for (int i = 0; i < 700; i++) begin
         if (i == 350) begin
            apply_reset();
            model_reset();
         end
         in_valid = ($urandom_range(0, 2) != 0);
         in_op    = 2'($urandom_range(0, 3));
         in_cnt   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15))
                                                : CNT_W'($urandom_range(0, 3));
         q_flip   = ($urandom_range(0, 399) == 0);
         v  = in_valid;
         o  = in_op;
         c  = int'(in_cnt);
         qf = ff_q ^ q_flip;
         @(posedge clk);
         model_edge(v, o, c, qf);
         @(negedge clk);
         chk($sformatf("rnd%0d_jk", i),    int'(jk),       int'(m_jk));
         chk($sformatf("rnd%0d_done", i),  int'(done),     int'(m_done));
         chk($sformatf("rnd%0d_busy", i),  int'(busy),     int'(m_cur_valid || (queued() > 0)));
         chk($sformatf("rnd%0d_ready", i), int'(in_ready), int'(queued() < DEPTH));
         chk($sformatf("rnd%0d_err", i),   int'(err),      int'(m_err));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
